// File: rtl/i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// i2c_slave_rx
//   I2C slave byte engine. Acknowledges SLAVE_ADDR, receives write data bytes
//   and returns tx_data on reads. SCL/SDA are expected to be deglitched
//   upstream; this block only registers them once for edge detection.
//
//   Optional feature: define I2C_GEN_CALL_EN to also acknowledge the general
//   call address (7'h00 with R/W=0) and receive its data like a normal write.
//
// Ports
//   clk        system clock, all logic on rising edge
//   rst        synchronous active-high reset
//   scl_in     filtered SCL
//   sda_in     filtered SDA
//   sda_oe     1 = pull SDA low (open-drain driver enable)
//   tx_data    byte returned on a read, captured when tx_load pulses
//   tx_load    1-clk pulse when tx_data is captured
//   rx_data    last received data byte
//   rx_valid   1-clk pulse when rx_data updates
//   start_det  1-clk pulse on START / repeated START
//   stop_det   1-clk pulse on STOP
//   busy       high from START until STOP
// ---------------------------------------------------------------------------
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_DATA,
    RX_ACK,
    TX_DATA,
    TX_ACK,
    WAIT_STOP
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic       rw_reg, rw_next;
  logic       sda_oe_reg, sda_oe_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       tx_load_reg, tx_load_next;
  logic       start_det_reg, stop_det_reg, busy_reg;
  logic       scl_d, sda_d;

  logic       scl_rise, scl_fall;
  logic       start_cond, stop_cond;
  logic [7:0] shift_in;
  logic       addr_hit;

  assign scl_rise = scl_in & ~scl_d;
  assign scl_fall = ~scl_in & scl_d;
  // Both conditions require SCL stable high, so a simultaneous SCL/SDA
  // change can never be mistaken for START or STOP.
  assign start_cond = sda_d & ~sda_in & scl_in & scl_d;
  assign stop_cond  = ~sda_d & sda_in & scl_in & scl_d;

  // Byte as it will look once the current SDA sample is shifted in.
  assign shift_in = {shift_reg[6:0], sda_in};

`ifdef I2C_GEN_CALL_EN
  assign addr_hit = (shift_in[7:1] == SLAVE_ADDR) || (shift_in == 8'h00);
`else
  assign addr_hit = (shift_in[7:1] == SLAVE_ADDR);
`endif

  // -------------------------------------------------------------------------
  // State and data registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      rw_reg        <= 1'b0;
      sda_oe_reg    <= 1'b0;
      rx_data_reg   <= 8'h00;
      rx_valid_reg  <= 1'b0;
      tx_load_reg   <= 1'b0;
      start_det_reg <= 1'b0;
      stop_det_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      scl_d         <= 1'b1;
      sda_d         <= 1'b1;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      rw_reg        <= rw_next;
      sda_oe_reg    <= sda_oe_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      tx_load_reg   <= tx_load_next;
      start_det_reg <= start_cond;
      stop_det_reg  <= stop_cond;
      scl_d         <= scl_in;
      sda_d         <= sda_in;
      if (start_cond)
        busy_reg <= 1'b1;
      else if (stop_cond)
        busy_reg <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    rw_next       = rw_reg;
    sda_oe_next   = sda_oe_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    tx_load_next  = 1'b0;

    if (start_cond) begin
      state_next   = ADDR;
      bit_cnt_next = 3'd0;
      shift_next   = 8'h00;
      sda_oe_next  = 1'b0;
    end else if (stop_cond) begin
      state_next  = IDLE;
      sda_oe_next = 1'b0;
    end else begin
      case (state_reg)
        ADDR: begin
          if (scl_rise) begin
            shift_next   = shift_in;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              rw_next    = sda_in;
              state_next = addr_hit ? ADDR_ACK : WAIT_STOP;
            end
          end
        end

        // The ACK phase spans two SCL falls: the first drives the ACK low,
        // the second ends it. sda_oe itself tells which fall this is.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_next = 1'b1;
            end else if (!rw_reg) begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = 3'd0;
              state_next   = RX_DATA;
            end else begin
              tx_load_next = 1'b1;
              shift_next   = tx_data;
              sda_oe_next  = ~tx_data[7];
              bit_cnt_next = 3'd0;
              state_next   = TX_DATA;
            end
          end
        end

        RX_DATA: begin
          if (scl_rise) begin
            shift_next   = shift_in;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              rx_data_next  = shift_in;
              rx_valid_next = 1'b1;
              state_next    = RX_ACK;
            end
          end
        end

        RX_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_next = 1'b1;
            end else begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = 3'd0;
              state_next   = RX_DATA;
            end
          end
        end

        // The MSB is already on the bus on entry; each fall presents the
        // next bit, and the fall after bit 0 hands SDA back to the master.
        TX_DATA: begin
          if (scl_fall) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              sda_oe_next = 1'b0;
              state_next  = TX_ACK;
            end else begin
              shift_next  = {shift_reg[6:0], 1'b0};
              sda_oe_next = ~shift_reg[6];
            end
          end
        end

        // A NACK leaves on the rise, so any fall seen here follows an ACK.
        TX_ACK: begin
          if (scl_rise && sda_in) begin
            state_next = WAIT_STOP;
          end else if (scl_fall) begin
            tx_load_next = 1'b1;
            shift_next   = tx_data;
            sda_oe_next  = ~tx_data[7];
            bit_cnt_next = 3'd0;
            state_next   = TX_DATA;
          end
        end

        default: ;
      endcase
    end

    if (state_next == IDLE || state_next == WAIT_STOP)
      sda_oe_next = 1'b0;
  end

  assign sda_oe    = sda_oe_reg;
  assign tx_load   = tx_load_reg;
  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign start_det = start_det_reg;
  assign stop_det  = stop_det_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_rx
//   Bit-banged I2C master driving i2c_slave_rx over an open-drain bus model.
//   Expected received bytes go into a queue that a monitor pops on rx_valid;
//   ACKs, read bytes and event counts come from a transaction-level model.
// ---------------------------------------------------------------------------
module tb_i2c_slave_rx;

  localparam logic [6:0] SADDR = 7'h50;
  localparam int Q = 4;  // clk cycles per quarter SCL period
`ifdef I2C_GEN_CALL_EN
  localparam bit GEN_CALL = 1'b1;
`else
  localparam bit GEN_CALL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_oe, tx_load, rx_valid, start_det, stop_det, busy;
  logic [7:0] rx_data;
  wire        sda_bus = sda_m & ~sda_oe;

  i2c_slave_rx #(.SLAVE_ADDR(SADDR)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .start_det(start_det),
    .stop_det (stop_det),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int start_cnt = 0, stop_cnt = 0, load_cnt = 0;
  int start_exp = 0, stop_exp = 0, load_exp = 0;
  bit oe_seen = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] pay[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor and event counters
  always @(negedge clk) begin
    if (start_det) start_cnt++;
    if (stop_det) stop_cnt++;
    if (tx_load) load_cnt++;
    if (sda_oe) oe_seen = 1'b1;
    if (rx_valid) begin
      if (exp_rx.size() == 0) begin
        check("rx_unexpected_valid", 32'(rx_valid), 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_rx.pop_front();
        check("rx_data", 32'(rx_data), 32'(e));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic bit addr_ack(input logic [7:0] a);
    return (a[7:1] == SADDR) || (GEN_CALL && a == 8'h00);
  endfunction

  // ---------------- bus primitives ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Works from idle (SCL high) and as a repeated START (SCL low).
  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_bus;  wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~master_ack);
  endtask

  task automatic post_txn_checks(input string tag);
    wait_clk(2);
    check({tag, "_start_cnt"}, 32'(start_cnt), 32'(start_exp));
    check({tag, "_stop_cnt"}, 32'(stop_cnt), 32'(stop_exp));
    check({tag, "_load_cnt"}, 32'(load_cnt), 32'(load_exp));
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_rx_pending"}, 32'(exp_rx.size()), 32'd0);
  endtask

  // Write transaction: address byte a (R/W=0 expected), payload from pay[].
  task automatic txn_write(input logic [7:0] a);
    logic ack;
    bit   hit;
    hit = addr_ack(a);
    start_exp++;
    bus_start();
    send_byte(a, ack);
    check("addr_ack", 32'(ack), 32'(hit));
    foreach (pay[i]) begin
      if (hit) exp_rx.push_back(pay[i]);
      send_byte(pay[i], ack);
      check("data_ack", 32'(ack), 32'(hit));
    end
    check("busy_before_stop", 32'(busy), 32'd1);
    bus_stop();
    stop_exp++;
    $display("txn write addr=%02h bytes=%0d acked=%0d", a, pay.size(), hit);
    post_txn_checks("wr");
  endtask

  // Read transaction of n bytes; master ACKs all but the last byte.
  task automatic txn_read(input logic [7:0] a, input int n);
    logic       ack;
    logic [7:0] d;
    bit         hit;
    hit = addr_ack(a);
    start_exp++;
    bus_start();
    send_byte(a, ack);
    check("addr_ack_rd", 32'(ack), 32'(hit));
    for (int i = 0; i < n; i++) begin
      if (hit) load_exp++;
      recv_byte(i < n - 1, d);
      check("read_byte", 32'(d), hit ? 32'(tx_data) : 32'hFF);
    end
    bus_stop();
    stop_exp++;
    $display("txn read  addr=%02h bytes=%0d tx_data=%02h acked=%0d", a, n, tx_data, hit);
    post_txn_checks("rd");
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic ack, b;
    logic [7:0] d;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_pulses", 32'({rx_valid, tx_load, start_det, stop_det}), 32'd0);
    $display("txn reset released");

    // Write two bytes to the slave
    pay = '{8'h3C, 8'hC3};
    txn_write(8'hA0);
    check("rx_data_last", 32'(rx_data), 32'hC3);

    // Read two bytes: ACK then NACK
    tx_data = 8'h96;
    txn_read(8'hA1, 2);

    // Foreign address: no ACK, SDA never pulled
    oe_seen = 1'b0;
    pay = '{8'h55};
    txn_write(8'hB0);
    check("foreign_no_oe", 32'(oe_seen), 32'd0);

    // Repeated START after 4 data bits
    start_exp++;
    bus_start();
    send_byte(8'hA0, ack);
    check("rs_addr_ack1", 32'(ack), 32'd1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    start_exp++;
    bus_start();
    send_byte(8'hA0, ack);
    check("rs_addr_ack2", 32'(ack), 32'd1);
    exp_rx.push_back(8'h5A);
    send_byte(8'h5A, ack);
    check("rs_data_ack", 32'(ack), 32'd1);
    bus_stop();
    stop_exp++;
    $display("txn repeated-start write 5A");
    post_txn_checks("rs");

    // Reset while the slave is ACKing a data byte
    start_exp++;
    bus_start();
    send_byte(8'hA0, ack);
    check("rr_addr_ack", 32'(ack), 32'd1);
    exp_rx.push_back(8'h77);
    d = 8'h77;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    sda_m = 1'b1;
    check("rr_ack_driven", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("rr_oe_after_rst", 32'(sda_oe), 32'd0);
    check("rr_busy_after_rst", 32'(busy), 32'd0);
    read_bit(b);
    check("rr_ack_gone", 32'(b), 32'd1);
    send_byte(8'hA0, ack);
    check("rr_ignored_addr", 32'(ack), 32'd0);
    send_byte(8'h11, ack);
    check("rr_ignored_data", 32'(ack), 32'd0);
    bus_stop();
    stop_exp++;
    $display("txn reset during RX ACK");
    post_txn_checks("rr");

    // General call address
    pay = '{8'h12};
    txn_write(8'h00);

    // Randomized transactions
    for (int r = 0; r < 16; r++) begin
      logic [6:0] a7;
      int sel, n;
      sel = $urandom_range(0, 3);
      a7 = (sel == 0 || sel == 3) ? SADDR : (sel == 1) ? 7'h00 : 7'($urandom);
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        tx_data = 8'($urandom);
        txn_read({a7, 1'b1}, n);
      end else begin
        pay.delete();
        for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
        txn_write({a7, 1'b0});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
